pipelined_subtractor: RTL

//   Two-stage pipelined unsigned subtractor d = a - b, plus a borrow-out flag.
//   It is the inverse-direction companion of the team's prefix adders and uses the same P/G prefix carry scheme.
//   It is built as a + ~b + 1, and the carry chain is split across two register stages.
//   It sits between valid/ready producers and consumers in the arithmetic datapath.

---
 rtl/arith_pkg.sv | 23 ++
 rtl/sub_pg_chunk.sv | 56 +++++
 rtl/pipelined_subtractor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Purpose : shared arithmetic definitions for the prefix adder/subtractor family.
// Latency : n/a (types, constants and helper function only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH  default operand width for the pipelined subtractor
//   lo_width()     number of low-order bits resolved in the first pipe stage
//   pg_t           per-bit / per-group propagate-generate pair
package arith_pkg;

  localparam int DEFAULT_WIDTH = 9;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Low half gets the floor; an odd width puts the extra bit in stage 2.
  function automatic int lo_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sub_pg_chunk.sv
// Purpose : N-bit combinational P/G prefix (Kogge-Stone) sum with carry-in.
// Latency : 0 cycles, purely combinational.
// Backpressure: none, no state.
//
// Ports:
//   x, y  [N-1:0]  addends (caller pre-inverts the subtrahend)
//   cin            carry into bit 0
//   sum   [N-1:0]  x + y + cin, low N bits
//   cout           carry out of bit N-1
module sub_pg_chunk
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // At least one prefix level so N=1 still has a well-formed array.
  localparam int LVLS = (N > 1) ? $clog2(N) : 1;

  // pre[l][i] holds the group P/G covering bits [i : max(0, i-2^l+1)].
  pg_t pre [LVLS+1][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pre[0][i].p = x[i] ^ y[i];
      pre[0][i].g = x[i] & y[i];
    end

    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < N; i++) begin
        // j is only meaningful when i >= 2^l; clamp keeps the index legal otherwise.
        int j;
        j = (i >= (1 << l)) ? i - (1 << l) : 0;
        if (i >= (1 << l)) begin
          pre[l+1][i].g = pre[l][i].g | (pre[l][i].p & pre[l][j].g);
          pre[l+1][i].p = pre[l][i].p & pre[l][j].p;
        end else begin
          pre[l+1][i] = pre[l][i];
        end
      end
    end

    // Carry into bit i folds cin through the group [i-1:0].
    sum[0] = pre[0][0].p ^ cin;
    for (int i = 1; i < N; i++) begin
      sum[i] = pre[0][i].p ^ (pre[LVLS][i-1].g | (pre[LVLS][i-1].p & cin));
    end
    cout = pre[LVLS][N-1].g | (pre[LVLS][N-1].p & cin);
  end

endmodule

// File: rtl/pipelined_subtractor.sv
// Purpose : two-stage pipelined unsigned subtractor d = a - b with borrow-out.
// Latency : 2 cycles from accept to out_valid, 1 result per cycle sustained.
// Backpressure: output holds while out_valid & ~out_ready; stage 1 holds when full; in_ready low when both full.
//
// Build option: define SUB_SATURATE_EN to clamp d to 0 whenever bout=1.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   in_valid / in_ready  input handshake for a, b (WIDTH bits each, unsigned)
//   out_valid / out_ready output handshake for d (WIDTH bits) and bout
//   d                    (a - b) mod 2^WIDTH (or clamped at 0 when saturating)
//   bout                 1 iff a < b
module pipelined_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LO_W  = lo_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int HI_W = WIDTH - LO_W;

  // Stage 1 registers: resolved low half plus the raw upper operands.
  logic              s1_valid_q, s1_valid_d;
  logic [LO_W-1:0]   s1_lo_q,    s1_lo_d;
  logic              s1_c_q,     s1_c_d;
  logic [HI_W-1:0]   s1_a_hi_q,  s1_a_hi_d;
  logic [HI_W-1:0]   s1_nb_hi_q, s1_nb_hi_d;

  // Stage 2 (output) registers.
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  d_q,         d_d;
  logic              bout_q,      bout_d;

  logic              adv2;
  logic              accept;
  logic [LO_W-1:0]   lo_sum;
  logic              lo_cout;
  logic [HI_W-1:0]   hi_sum;
  logic              hi_cout;
  logic [LO_W-1:0]   b_lo_n;

  assign b_lo_n = ~b[LO_W-1:0];

  // a - b == a + ~b + 1: the "+1" enters as the low chunk's carry-in.
  sub_pg_chunk #(.N(LO_W)) u_lo (
    .x    (a[LO_W-1:0]),
    .y    (b_lo_n),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  sub_pg_chunk #(.N(HI_W)) u_hi (
    .x    (s1_a_hi_q),
    .y    (s1_nb_hi_q),
    .cin  (s1_c_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Stage 2 can take a new result when empty or when its current one is popped.
  assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | adv2;
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_c_d      = s1_c_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_nb_hi_d  = s1_nb_hi_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    bout_d      = bout_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_sum;
      s1_c_d     = lo_cout;
      s1_a_hi_d  = a[WIDTH-1:LO_W];
      s1_nb_hi_d = ~b[WIDTH-1:LO_W];
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      out_valid_d = 1'b1;
      // No carry out of a + ~b + 1 means the subtraction borrowed.
      bout_d      = ~hi_cout;
`ifdef SUB_SATURATE_EN
      d_d         = hi_cout ? {hi_sum, s1_lo_q} : '0;
`else
      d_d         = {hi_sum, s1_lo_q};
`endif
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_nb_hi_q  <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_nb_hi_q  <= s1_nb_hi_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;

endmodule
